// File: rtl/serial_comparator_ctrl.sv
// MSB-first serial magnitude comparator: one bit per clock through a 1-bit
// comparator cell, exiting at the first differing bit with a registered verdict.

module comparator (
  input  logic i_w_a,
  input  logic i_w_b,
  output logic o_w_lt,
  output logic o_w_gt,
  output logic o_w_eq
);
  assign o_w_lt = ~i_w_a &  i_w_b;
  assign o_w_gt =  i_w_a & ~i_w_b;
  assign o_w_eq = ~(i_w_a ^ i_w_b);
endmodule

module serial_comparator_ctrl #(
  parameter int WIDTH = 8,
  parameter int PW    = $clog2(WIDTH)
) (
  input  logic             i_w_clk,
  input  logic             i_w_rst_n,
  input  logic             i_w_start,
  input  logic [WIDTH-1:0] i_w_a,
  input  logic [WIDTH-1:0] i_w_b,
  output logic             o_w_busy,
  output logic             o_w_done,
  output logic             o_w_lt,
  output logic             o_w_gt,
  output logic             o_w_eq,
  output logic [PW-1:0]    o_w_pos
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [PW-1:0] IDX_MAX = PW'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [PW-1:0]      idx_q, idx_d;
  logic               lt_q, lt_d;
  logic               gt_q, gt_d;
  logic               eq_q, eq_d;
  logic [PW-1:0]      pos_q, pos_d;

  logic               bit_a;
  logic               bit_b;
  logic               cmp_lt;
  logic               cmp_gt;
  logic               cmp_eq;

  // The bit under test comes from the captured operands, never the live inputs.
  assign bit_a = a_q[idx_q];
  assign bit_b = b_q[idx_q];

  comparator u_cmp (
    .i_w_a  (bit_a),
    .i_w_b  (bit_b),
    .o_w_lt (cmp_lt),
    .o_w_gt (cmp_gt),
    .o_w_eq (cmp_eq)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    lt_d    = lt_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    pos_d   = pos_q;

    case (state_q)
      ST_IDLE: begin
        if (i_w_start) begin
          a_d     = i_w_a;
          b_d     = i_w_b;
          idx_d   = IDX_MAX;
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          pos_d   = '0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (cmp_gt || cmp_lt) begin
          gt_d    = cmp_gt;
          lt_d    = cmp_lt;
          pos_d   = idx_q;
          state_d = ST_DONE;
        end else if (cmp_eq && (idx_q == '0)) begin
          // Every bit matched; the index stops here instead of wrapping.
          eq_d    = 1'b1;
          pos_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q - 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      pos_q   <= pos_d;
    end
  end

  assign o_w_busy = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign o_w_done = (state_q == ST_DONE);
  assign o_w_lt   = lt_q;
  assign o_w_gt   = gt_q;
  assign o_w_eq   = eq_q;
  assign o_w_pos  = pos_q;

endmodule
